// File: rtl/fifo_pkg.sv
// Shared types and default sizes for the FIFO and its reader.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    POP     = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } rd_state_e;

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO-side and downstream-side signals of the reader; master = reader, slave = FIFO/sink side.
interface fifo_reader_if #(
  parameter int WIDTH = fifo_pkg::FIFO_WIDTH,
  parameter int CNT_W = fifo_pkg::FIFO_CNT_W
) ();

  logic             F_EMPTY_N;
  logic [CNT_W-1:0] USE_DW;
  logic [WIDTH-1:0] FIFO_DATA;
  logic             READ;
  logic [WIDTH-1:0] DOUT;
  logic             DOUT_VALID;
  logic             DOUT_READY;

  modport master (
    input  F_EMPTY_N, USE_DW, FIFO_DATA, DOUT_READY,
    output READ, DOUT, DOUT_VALID
  );

  modport slave (
    output F_EMPTY_N, USE_DW, FIFO_DATA, DOUT_READY,
    input  READ, DOUT, DOUT_VALID
  );

endinterface

// File: rtl/fifo.sv
// Generic synchronous FIFO, depth 2**(CNT_W-1); read data is registered one cycle after rd_en_i.
// Writes when full and reads when empty are ignored.
module fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_dat_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             empty_n_o,
  output logic [CNT_W-1:0] used_o
);

  localparam int AW    = CNT_W - 1;
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] used_q;
  logic [WIDTH-1:0] rd_dat_q;
  logic             do_wr, do_rd;

  assign do_wr = wr_en_i && (used_q != CNT_W'(DEPTH));
  assign do_rd = rd_en_i && (used_q != '0);

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
      rd_dat_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rd_dat_q <= mem_q[rd_ptr_q];
      end
      case ({do_wr, do_rd})
        2'b10:   used_q <= used_q + CNT_W'(1);
        2'b01:   used_q <= used_q - CNT_W'(1);
        default: used_q <= used_q;
      endcase
    end
  end

  assign rd_dat_o  = rd_dat_q;
  assign empty_n_o = (used_q != '0);
  assign used_o    = used_q;

endmodule

// File: rtl/fifo_reader.sv
// Drains a 1-cycle-latency FIFO into a registered output word, one word per 3 cycles.
// Draining starts at THRESHOLD occupancy or on FLUSH; DOUT holds while DOUT_READY is low.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             CLEAR_N,
  input  logic [CNT_W-1:0] THRESHOLD,
  input  logic             FLUSH,
  output logic [15:0]      RD_COUNT,
  fifo_reader_if.master    bus
);

  rd_state_e        state_q;
  logic             pop_q;
  logic             vld_q;
  logic             drain_q;
  logic [WIDTH-1:0] dout_q;
  logic [15:0]      rd_count_q, rd_count_d;
  logic [CNT_W-1:0] thr_eff;
  logic             start;

  assign thr_eff    = (THRESHOLD == '0) ? CNT_W'(1) : THRESHOLD;
  assign start      = bus.F_EMPTY_N && ((bus.USE_DW >= thr_eff) || FLUSH);
  assign rd_count_d = rd_count_q + 16'd1;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= IDLE;
      pop_q      <= 1'b0;
      vld_q      <= 1'b0;
      drain_q    <= 1'b0;
      dout_q     <= '0;
      rd_count_q <= '0;
    end else if (!CLEAR_N) begin
      // dout_q deliberately survives a clear
      state_q    <= IDLE;
      pop_q      <= 1'b0;
      vld_q      <= 1'b0;
      drain_q    <= 1'b0;
      rd_count_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) drain_q <= 1'b1;
          if (start || (drain_q && bus.F_EMPTY_N)) begin
            state_q <= POP;
            pop_q   <= 1'b1;
          end
        end
        POP: begin
          pop_q   <= 1'b0;
          state_q <= bus.F_EMPTY_N ? CAPTURE : IDLE;
        end
        CAPTURE: begin
          dout_q  <= bus.FIFO_DATA;
          vld_q   <= 1'b1;
          state_q <= PRESENT;
        end
        PRESENT: begin
          if (bus.DOUT_READY) begin
            vld_q      <= 1'b0;
            rd_count_q <= rd_count_d;
            if (!bus.F_EMPTY_N) drain_q <= 1'b0;
            if (drain_q && bus.F_EMPTY_N) begin
              state_q <= POP;
              pop_q   <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pop_q   <= 1'b0;
        end
      endcase
    end
  end

  // The pop strobe is gated by the live flag so an empty FIFO is never read.
  assign bus.READ       = pop_q && bus.F_EMPTY_N;
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = vld_q;
  assign RD_COUNT       = rd_count_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with the generic fifo beside it and a word scoreboard.
module tb_fifo_reader;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clr_n, flush, wr_en;
  logic [4:0]  thr;
  logic [7:0]  wr_dat;
  logic [15:0] rd_count;

  int          checks = 0;
  int          errors = 0;
  int          rd_pulses = 0;
  int          n;
  int          rd_before;
  logic [7:0]  exp_q [$];

  always #5 clk = ~clk;

  fifo_reader_if #(.WIDTH(8), .CNT_W(5)) bus ();

  fifo #(.WIDTH(8), .CNT_W(5)) u_fifo (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .wr_en_i  (wr_en),
    .wr_dat_i (wr_dat),
    .rd_en_i  (bus.READ),
    .rd_dat_o (bus.FIFO_DATA),
    .empty_n_o(bus.F_EMPTY_N),
    .used_o   (bus.USE_DW)
  );

  fifo_reader #(.WIDTH(8), .CNT_W(5)) dut (
    .CLOCK    (clk),
    .RESET_N  (rst_n),
    .CLEAR_N  (clr_n),
    .THRESHOLD(thr),
    .FLUSH    (flush),
    .RD_COUNT (rd_count),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en  = 1'b1;
    wr_dat = d;
    exp_q.push_back(d);
    cyc();
    wr_en  = 1'b0;
  endtask

  // Scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.READ) rd_pulses++;
    if (rst_n && bus.READ) chk("read_while_empty", 32'(bus.F_EMPTY_N), 32'd1);
    if (rst_n && clr_n && bus.DOUT_VALID && bus.DOUT_READY) begin
      if (exp_q.size() == 0) chk("sb_word_expected", 32'(exp_q.size()), 32'd1);
      else                   chk("dout_word", 32'(bus.DOUT), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clr_n = 1'b1; flush = 1'b0; wr_en = 1'b0; wr_dat = 8'h00; thr = 5'd4;
    bus.DOUT_READY = 1'b1;
    #12;
    chk("rst_read",  32'(bus.READ),       32'd0);
    chk("rst_dout",  32'(bus.DOUT),       32'd0);
    chk("rst_valid", 32'(bus.DOUT_VALID), 32'd0);
    chk("rst_count", 32'(rd_count),       32'd0);
    chk("rst_state", 32'(dut.state_q),    32'(IDLE));
    cyc();
    rst_n = 1'b1;

    // Empty FIFO: nothing may happen
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_read",  32'(bus.READ),       32'd0);
      chk("idle_valid", 32'(bus.DOUT_VALID), 32'd0);
      chk("idle_count", 32'(rd_count),       32'd0);
    end

    // Threshold 4: three words wait, the fourth triggers a full drain
    push(8'h11); push(8'h22); push(8'h33);
    repeat (6) cyc();
    chk("thr_below_reads", 32'(rd_pulses), 32'd0);
    chk("thr_below_valid", 32'(bus.DOUT_VALID), 32'd0);
    push(8'h44);
    n = 0;
    while (rd_count != 16'd4 && n < 40) begin cyc(); n++; end
    chk("drain4_cycles", 32'(n), 32'd13);
    chk("drain4_count",  32'(rd_count), 32'd4);
    chk("drain4_state",  32'(dut.state_q), 32'(IDLE));
    chk("drain4_empty",  32'(bus.F_EMPTY_N), 32'd0);
    chk("drain4_flag",   32'(dut.drain_q), 32'd0);
    chk("drain4_reads",  32'(rd_pulses), 32'd4);
    chk("drain4_sb",     32'(exp_q.size()), 32'd0);

    // Flush below threshold, then backpressure for 7 cycles
    thr = 5'd31;
    bus.DOUT_READY = 1'b0;
    push(8'hA5);
    repeat (4) cyc();
    chk("flush_pre_reads", 32'(rd_pulses), 32'd4);
    flush = 1'b1;
    n = 0;
    while (!bus.READ && n < 20) begin cyc(); n++; end
    chk("flush_read_seen", 32'(bus.READ), 32'd1);
    chk("flush_read_lat",  32'(n), 32'd1);
    cyc();
    chk("flush_valid_early", 32'(bus.DOUT_VALID), 32'd0);
    cyc();
    chk("flush_valid", 32'(bus.DOUT_VALID), 32'd1);
    chk("flush_dout",  32'(bus.DOUT), 32'hA5);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("hold_dout",  32'(bus.DOUT), 32'hA5);
      chk("hold_valid", 32'(bus.DOUT_VALID), 32'd1);
    end
    chk("hold_reads", 32'(rd_pulses), 32'd5);
    chk("hold_state", 32'(dut.state_q), 32'(PRESENT));
    bus.DOUT_READY = 1'b1;
    cyc();
    chk("hold_xfer_count", 32'(rd_count), 32'd5);
    chk("hold_xfer_valid", 32'(bus.DOUT_VALID), 32'd0);
    repeat (3) cyc();
    chk("hold_post_reads", 32'(rd_pulses), 32'd5);

    // Clear in PRESENT beats FLUSH and DOUT_READY; DOUT is kept
    bus.DOUT_READY = 1'b0;
    push(8'h5A);
    n = 0;
    while (!bus.DOUT_VALID && n < 10) begin cyc(); n++; end
    chk("clr_pre_valid", 32'(bus.DOUT_VALID), 32'd1);
    clr_n = 1'b0;
    bus.DOUT_READY = 1'b1;
    cyc();
    chk("clr_state", 32'(dut.state_q), 32'(IDLE));
    chk("clr_valid", 32'(bus.DOUT_VALID), 32'd0);
    chk("clr_count", 32'(rd_count), 32'd0);
    chk("clr_drain", 32'(dut.drain_q), 32'd0);
    chk("clr_dout",  32'(bus.DOUT), 32'h5A);
    clr_n = 1'b1;
    void'(exp_q.pop_front());

    // Asynchronous reset while in POP
    push(8'h66);
    push(8'h77);
    n = 0;
    while (!bus.READ && n < 10) begin cyc(); n++; end
    chk("rstpop_read_seen", 32'(bus.READ), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstpop_read",  32'(bus.READ), 32'd0);
    chk("rstpop_valid", 32'(bus.DOUT_VALID), 32'd0);
    chk("rstpop_dout",  32'(bus.DOUT), 32'd0);
    chk("rstpop_count", 32'(rd_count), 32'd0);
    chk("rstpop_state", 32'(dut.state_q), 32'(IDLE));
    rd_before = rd_pulses;
    exp_q.delete();
    flush = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    chk("rstpop_first_read", 32'(bus.READ), 32'd0);
    cyc();
    chk("rstpop_next_read", 32'(bus.READ), 32'd0);
    chk("rstpop_no_pop",    32'(rd_pulses), 32'(rd_before));

    // Threshold 0 behaves as 1
    thr = 5'd0;
    push(8'h81);
    n = 0;
    while (rd_count != 16'd1 && n < 20) begin cyc(); n++; end
    chk("thr0_count",  32'(rd_count), 32'd1);
    chk("thr0_cycles", 32'(n), 32'd4);
    chk("thr0_sb",     32'(exp_q.size()), 32'd0);

    // Counter wraps silently
    force dut.rd_count_q = 16'hFFFF;
    #1;
    release dut.rd_count_q;
    chk("wrap_preset", 32'(rd_count), 32'hFFFF);
    push(8'h3C);
    n = 0;
    while (rd_count == 16'hFFFF && n < 20) begin cyc(); n++; end
    chk("wrap_count", 32'(rd_count), 32'd0);
    chk("wrap_sb",    32'(exp_q.size()), 32'd0);

    repeat (3) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
